// File: rtl/inst_sequencer.sv
// TABLA PE instruction sequencer: streams instruction memory words 0..lastAddr for
// numIter passes to the decoder, with a one-entry skid buffer covering read latency.
module inst_sequencer #(
  parameter int fnLen    = 3,
  parameter int nameLen  = 3,
  parameter int indexLen = 8,
  parameter int instLen  = fnLen + 6*nameLen + 6*indexLen,
  parameter int addrLen  = 8,
  parameter int iterLen  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [addrLen-1:0] lastAddr,
  input  logic [iterLen-1:0] numIter,
  input  logic               stall,
  output logic [addrLen-1:0] instMemAddr,
  output logic               instMemRdEn,
  input  logic [instLen-1:0] instMemData,
  output logic [instLen-1:0] instword,
  output logic               instword_v,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e               state_q, state_d;
  logic [addrLen-1:0]   pc_q, pc_d, last_q, last_d;
  logic [iterLen-1:0]   iter_q, iter_d, iter_last_q, iter_last_d;
  logic                 inflight_q, inflight_d;
  logic [instLen-1:0]   out_q, out_d, skid_q, skid_d;
  logic                 out_v_q, out_v_d, skid_v_q, skid_v_d;
  logic                 done_q, done_d;
  logic                 rd_en, final_rd, consume;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    iter_d      = iter_q;
    last_d      = last_q;
    iter_last_d = iter_last_q;
    out_d       = out_q;
    out_v_d     = out_v_q;
    skid_d      = skid_q;
    skid_v_d    = skid_v_q;
    done_d      = 1'b0;

    rd_en      = (state_q == RUN) && !stall && !skid_v_q;
    final_rd   = rd_en && (pc_q == last_q) && (iter_q == iter_last_q);
    consume    = out_v_q && !stall;
    inflight_d = rd_en;

    // Skid only fills while the output is stalled, and a stall blocks the read
    // that would land next cycle, so skid and returning data never collide.
    if (consume) begin
      if (skid_v_q) begin
        out_d    = skid_q;
        skid_v_d = 1'b0;
      end else if (inflight_q) begin
        out_d = instMemData;
      end else begin
        out_v_d = 1'b0;
      end
    end else if (inflight_q) begin
      if (!out_v_q) begin
        out_d   = instMemData;
        out_v_d = 1'b1;
      end else begin
        skid_d   = instMemData;
        skid_v_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          last_d      = lastAddr;
          iter_last_d = (numIter == '0) ? '0 : numIter - iterLen'(1);
          pc_d        = '0;
          iter_d      = '0;
        end
      end
      RUN: begin
        if (rd_en) begin
          if (pc_q == last_q) begin
            pc_d   = '0;
            iter_d = iter_q + iterLen'(1);
          end else begin
            pc_d = pc_q + addrLen'(1);
          end
        end
        if (final_rd) state_d = DRAIN;
      end
      DRAIN: begin
        if (!out_v_d && !skid_v_d && !inflight_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      iter_q      <= '0;
      last_q      <= '0;
      iter_last_q <= '0;
      inflight_q  <= 1'b0;
      out_q       <= '0;
      out_v_q     <= 1'b0;
      skid_q      <= '0;
      skid_v_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      iter_q      <= iter_d;
      last_q      <= last_d;
      iter_last_q <= iter_last_d;
      inflight_q  <= inflight_d;
      out_q       <= out_d;
      out_v_q     <= out_v_d;
      skid_q      <= skid_d;
      skid_v_q    <= skid_v_d;
      done_q      <= done_d;
    end
  end

  assign instMemAddr = pc_q;
  assign instMemRdEn = rd_en;
  assign instword    = out_v_q ? out_q : '0;
  assign instword_v  = out_v_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;

endmodule

// File: doc/inst_sequencer.md
# inst_sequencer

Instruction sequencer for a TABLA processing element. It walks the PE instruction memory from address 0 to `lastAddr` for `numIter` passes and presents each word, with a valid flag, to the PE instruction decoder. A downstream `stall` holds the presented word without loss or duplication. A one-entry skid buffer absorbs the one-cycle synchronous-read latency of the instruction memory.

## Interface
Parameters:
- `fnLen`, 3, function-field width
- `nameLen`, 3, operand-name width
- `indexLen`, 8, operand-index width
- `instLen`, fnLen + 6*nameLen + 6*indexLen (69), instruction word width
- `addrLen`, 8, instruction memory address width
- `iterLen`, 16, iteration counter width

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
  - `clk` in 1: clock
  - `reset` in 1: asynchronous, active-high reset
- Control:
  - `start` in 1: single-cycle start request; sampled only in IDLE
  - `lastAddr` in addrLen: address of the final instruction; sampled with `start`
  - `numIter` in iterLen: number of program passes, sampled with `start`; 0 is treated as 1
  - `stall` in 1: decoder cannot accept; hold the current word
- Instruction memory:
  - `instMemAddr` out addrLen: read address
  - `instMemRdEn` out 1: read enable
  - `instMemData` in instLen: read data, valid the cycle after `instMemRdEn`
- Decoder side:
  - `instword` out instLen: current instruction word
  - `instword_v` out 1: `instword` valid
- Status:
  - `busy` out 1: high from the first RUN cycle until the last word is consumed
  - `done` out 1: one-cycle pulse after the last word is consumed

## Operation
- States: IDLE, RUN, DRAIN.
  - IDLE -> RUN on `start`. Latch `lastAddr` and `numIter`; clear pc and iteration count.
  - RUN -> DRAIN when the final read (pc == lastAddr, final iteration) is issued.
  - DRAIN -> IDLE when the output register and skid buffer are both empty and no read is in flight. `done` pulses on that transition.
- Read issue: `instMemRdEn` = RUN & !stall & skid empty.
  - On every issued read, pc increments.
  - pc == lastAddr wraps to 0 and increments the iteration count.
- Returning data:
  - Goes to the output register if that register is empty or is being consumed this cycle.
  - Otherwise it goes to the skid buffer.
- Consumption: a word is consumed in any cycle with `instword_v`=1 and `stall`=0.
  - On consumption, the output register reloads from the skid buffer first; otherwise it reloads from returning memory data.
- Ordering: words appear strictly in address order, each exactly once per iteration.
- When `instword_v`=0, `instword` is driven 0.
- `start` is ignored outside IDLE.
- `lastAddr`/`numIter` changes after `start` have no effect on the running program.

## Timing
- Reset values: state IDLE; pc 0; iteration count 0; skid empty.
  - All outputs 0: `instMemAddr`, `instMemRdEn`, `instword`, `instword_v`, `busy`, `done`.
- Reset mid-run: an immediate return to IDLE with all of the reset values above. The in-flight read is discarded and the next `start` begins a fresh program.
- Start latency:
  - `start` high in cycle 0 -> first read (addr 0) issued in cycle 1, `busy`=1 from cycle 1.
  - First word has `instword_v`=1 in cycle 3.
- No-stall throughput: one read and one word per cycle; iteration wrap adds no bubble.
- Word presentation: address issued in cycle t -> word presented in cycle t+2 at the earliest.
- Stall: with `stall`=1 in cycle t, no read is issued in t, and `instword`/`instword_v` in t+1 equal their values in t.
  - The read issued in t-1 lands in the skid buffer if the output register is occupied.
  - After `stall` falls, the skid word is presented next; reads resume once the skid buffer is empty (at most one bubble).
- Completion:
  - The last word is consumed in cycle c.
  - `busy`=0 and `done`=1 in cycle c+1; `done`=0 in c+2.
  - A `start` in c+1 is accepted.
- Single-instruction program: `lastAddr`=0 is legal.

## Test plan
- No stall:
  - Stimulus: `lastAddr`=3, `numIter`=1, `start` in cycle 0.
  - Required: addresses 0,1,2,3 with `instMemRdEn`=1 in cycles 1-4; `instword`=M[0..3] with `instword_v`=1 in cycles 3-6; `done` pulse in cycle 7; `busy`=1 exactly for cycles 1-6.
- Iteration wrap:
  - Stimulus: `lastAddr`=1, `numIter`=3.
  - Required: 6 words M0,M1,M0,M1,M0,M1 back to back with no bubble; exactly one `done`.
- Stall mid-stream:
  - Stimulus: `lastAddr`=7, `numIter`=1; `stall` high for 3 cycles while M[2] is presented.
  - Required: M[2] held for all 3 cycles; next words M[3..7] in order with no loss or duplicate; total of 8 consumptions.
- `numIter`=0 plus late `start`:
  - Stimulus: `lastAddr`=0, `numIter`=0; a second `start` pulse while `busy`=1.
  - Required: a single M[0] word, one `done`, and the second `start` ignored.
- Reset mid-run:
  - Stimulus: `reset` asserted in cycle 4 of a `lastAddr`=7 run.
  - Required: all outputs 0 from the reset assertion; after release, a new `start` presents M[0] first.
- Back-to-back programs:
  - Stimulus: `start` asserted in the same cycle as `done`.
  - Required: the second program runs with its newly latched `lastAddr`, and the first word is presented 3 cycles after that `start`.
